// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-1 control sequencer: opcodes, T-state
// indices and the control-word bit layout used by the controller and bench.
package sap_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int NUM_T = 6;
    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;
    localparam int T5 = 4;
    localparam int T6 = 5;

    localparam int CW_PC_INC    = 0;
    localparam int CW_PC_EN     = 1;
    localparam int CW_MAR_LATCH = 2;
    localparam int CW_RAM_EN    = 3;
    localparam int CW_IR_LATCH  = 4;
    localparam int CW_IR_EN     = 5;
    localparam int CW_A_LATCH   = 6;
    localparam int CW_A_EN      = 7;
    localparam int CW_B_LATCH   = 8;
    localparam int CW_ALU_SUB   = 9;
    localparam int CW_ALU_EN    = 10;
    localparam int CW_OUT_LATCH = 11;
    localparam int CW_W         = 12;

    typedef logic [CW_W-1:0]  cw_t;
    typedef logic [NUM_T-1:0] ring_t;

    typedef enum logic [2:0] {
        INS_LDA,
        INS_ADD,
        INS_SUB,
        INS_OUT,
        INS_HLT,
        INS_NOP
    } ins_e;

endpackage

// File: rtl/sap_ring_counter.sv
// Six-step one-hot ring (T1..T6) with hold, early wrap back to T1 and a
// freeze input that pins the current step while the machine is halted.
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  advance,
    input  logic  early_wrap,
    input  logic  freeze,
    output ring_t ring
);

    ring_t ring_reg;
    ring_t ring_next;
    ring_t rotated;

    for (genvar gi = 0; gi < NUM_T; gi++) begin : g_rot
        assign rotated[gi] = ring_reg[(gi + NUM_T - 1) % NUM_T];
    end

    always_comb begin
        ring_next = ring_reg;
        if (advance && !freeze) begin
            ring_next = early_wrap ? ring_t'(1) : rotated;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ring_reg <= ring_t'(1);
        end else begin
            ring_reg <= ring_next;
        end
    end

    assign ring = ring_reg;

endmodule

// File: rtl/sap_controller.sv
// SAP-1 control sequencer: decodes the T-state ring and IR opcode into one
// Moore control word per clock; HLT freezes the ring at T4 until reset.
module sap_controller
    import sap_pkg::*;
#(
    parameter int OPCODE_W    = 4,
    parameter bit SHORT_CYCLE = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step_en,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [5:0]          t_state,
    output logic                halted,
    output logic                pc_inc,
    output logic                pc_en,
    output logic                mar_latch,
    output logic                ram_en,
    output logic                ir_latch,
    output logic                ir_en,
    output logic                a_latch,
    output logic                a_en,
    output logic                b_latch,
    output logic                alu_sub,
    output logic                alu_en,
    output logic                out_latch
);

    ring_t ring;
    ins_e  ins;
    logic  halted_reg;
    logic  halted_next;
    logic  halt_now;
    logic  early_wrap;
    cw_t   cw;

    always_comb begin
        if (opcode == OPCODE_W'(OP_LDA))      ins = INS_LDA;
        else if (opcode == OPCODE_W'(OP_ADD)) ins = INS_ADD;
        else if (opcode == OPCODE_W'(OP_SUB)) ins = INS_SUB;
        else if (opcode == OPCODE_W'(OP_OUT)) ins = INS_OUT;
        else if (opcode == OPCODE_W'(OP_HLT)) ins = INS_HLT;
        else                                  ins = INS_NOP;
    end

    sap_ring_counter u_ring (
        .clk        (clk),
        .reset      (reset),
        .advance    (step_en),
        .early_wrap (early_wrap),
        .freeze     (halted_reg | halt_now),
        .ring       (ring)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            halted_reg <= 1'b0;
        end else begin
            halted_reg <= halted_next;
        end
    end

    // Halt latches at the end of T4 even if the step is being held.
    always_comb begin
        halt_now    = ring[T4] && (ins == INS_HLT);
        halted_next = halted_reg | halt_now;
        early_wrap  = 1'b0;
        if (SHORT_CYCLE) begin
            early_wrap = (ring[T5] && ins == INS_LDA) ||
                         (ring[T4] && ins == INS_OUT) ||
                         (ring[T3] && ins == INS_NOP);
        end
    end

    always_comb begin
        cw = '0;
        if (!reset && !halted_reg) begin
            if (ring[T1]) begin
                cw[CW_PC_EN]     = 1'b1;
                cw[CW_MAR_LATCH] = 1'b1;
            end else if (ring[T2]) begin
                cw[CW_PC_INC] = 1'b1;
            end else if (ring[T3]) begin
                cw[CW_RAM_EN]   = 1'b1;
                cw[CW_IR_LATCH] = 1'b1;
            end else if (ring[T4]) begin
                if (ins == INS_LDA || ins == INS_ADD || ins == INS_SUB) begin
                    cw[CW_IR_EN]     = 1'b1;
                    cw[CW_MAR_LATCH] = 1'b1;
                end else if (ins == INS_OUT) begin
                    cw[CW_A_EN]      = 1'b1;
                    cw[CW_OUT_LATCH] = 1'b1;
                end
            end else if (ring[T5]) begin
                if (ins == INS_LDA) begin
                    cw[CW_RAM_EN]  = 1'b1;
                    cw[CW_A_LATCH] = 1'b1;
                end else if (ins == INS_ADD || ins == INS_SUB) begin
                    cw[CW_RAM_EN]  = 1'b1;
                    cw[CW_B_LATCH] = 1'b1;
                end
            end else if (ring[T6]) begin
                if (ins == INS_ADD || ins == INS_SUB) begin
                    cw[CW_ALU_EN]  = 1'b1;
                    cw[CW_A_LATCH] = 1'b1;
                    cw[CW_ALU_SUB] = (ins == INS_SUB);
                end
            end
        end
    end

    assign t_state   = ring;
    assign halted    = halted_reg;
    assign pc_inc    = cw[CW_PC_INC];
    assign pc_en     = cw[CW_PC_EN];
    assign mar_latch = cw[CW_MAR_LATCH];
    assign ram_en    = cw[CW_RAM_EN];
    assign ir_latch  = cw[CW_IR_LATCH];
    assign ir_en     = cw[CW_IR_EN];
    assign a_latch   = cw[CW_A_LATCH];
    assign a_en      = cw[CW_A_EN];
    assign b_latch   = cw[CW_B_LATCH];
    assign alu_sub   = cw[CW_ALU_SUB];
    assign alu_en    = cw[CW_ALU_EN];
    assign out_latch = cw[CW_OUT_LATCH];

endmodule

// File: tb/tb_sap_controller.sv
// Scoreboard bench for sap_controller: one full-cycle instance and one
// short-cycle instance driven with directed, hand-computed control words.
module tb_sap_controller;
    import sap_pkg::*;

    localparam ring_t S1 = 6'b000001;
    localparam ring_t S2 = 6'b000010;
    localparam ring_t S3 = 6'b000100;
    localparam ring_t S4 = 6'b001000;
    localparam ring_t S5 = 6'b010000;
    localparam ring_t S6 = 6'b100000;

    localparam cw_t W_0   = '0;
    localparam cw_t W_T1  = cw_t'((1 << CW_PC_EN) | (1 << CW_MAR_LATCH));
    localparam cw_t W_T2  = cw_t'(1 << CW_PC_INC);
    localparam cw_t W_T3  = cw_t'((1 << CW_RAM_EN) | (1 << CW_IR_LATCH));
    localparam cw_t W_ADR = cw_t'((1 << CW_IR_EN) | (1 << CW_MAR_LATCH));
    localparam cw_t W_LDB = cw_t'((1 << CW_RAM_EN) | (1 << CW_B_LATCH));
    localparam cw_t W_LDA = cw_t'((1 << CW_RAM_EN) | (1 << CW_A_LATCH));
    localparam cw_t W_ADD = cw_t'((1 << CW_ALU_EN) | (1 << CW_A_LATCH));
    localparam cw_t W_SUB = cw_t'((1 << CW_ALU_EN) | (1 << CW_A_LATCH) | (1 << CW_ALU_SUB));
    localparam cw_t W_OUT = cw_t'((1 << CW_A_EN) | (1 << CW_OUT_LATCH));
    localparam logic [3:0] OP_NOP = 4'b0101;

    typedef struct {
        int    sel;
        ring_t t;
        logic  h;
        cw_t   cw;
        string nm;
    } sb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset0, step_en0, reset1, step_en1;
    logic [3:0] opcode0, opcode1;
    wire [5:0]  t_state0, t_state1;
    wire        halted0, halted1;
    wire [CW_W-1:0] act0, act1;

    int  checks = 0;
    int  passed = 0;
    bit  mon_on = 1'b0;
    sb_t sbq[$];
    sb_t e;

    sap_controller #(.OPCODE_W(4), .SHORT_CYCLE(1'b0)) dut0 (
        .clk(clk), .reset(reset0), .step_en(step_en0), .opcode(opcode0),
        .t_state(t_state0), .halted(halted0),
        .pc_inc(act0[CW_PC_INC]), .pc_en(act0[CW_PC_EN]), .mar_latch(act0[CW_MAR_LATCH]),
        .ram_en(act0[CW_RAM_EN]), .ir_latch(act0[CW_IR_LATCH]), .ir_en(act0[CW_IR_EN]),
        .a_latch(act0[CW_A_LATCH]), .a_en(act0[CW_A_EN]), .b_latch(act0[CW_B_LATCH]),
        .alu_sub(act0[CW_ALU_SUB]), .alu_en(act0[CW_ALU_EN]), .out_latch(act0[CW_OUT_LATCH])
    );

    sap_controller #(.OPCODE_W(4), .SHORT_CYCLE(1'b1)) dut1 (
        .clk(clk), .reset(reset1), .step_en(step_en1), .opcode(opcode1),
        .t_state(t_state1), .halted(halted1),
        .pc_inc(act1[CW_PC_INC]), .pc_en(act1[CW_PC_EN]), .mar_latch(act1[CW_MAR_LATCH]),
        .ram_en(act1[CW_RAM_EN]), .ir_latch(act1[CW_IR_LATCH]), .ir_en(act1[CW_IR_EN]),
        .a_latch(act1[CW_A_LATCH]), .a_en(act1[CW_A_EN]), .b_latch(act1[CW_B_LATCH]),
        .alu_sub(act1[CW_ALU_SUB]), .alu_en(act1[CW_ALU_EN]), .out_latch(act1[CW_OUT_LATCH])
    );

    // Drive one cycle of stimulus on the selected instance and queue its expected outputs.
    task automatic cyc(input int sel, input logic rst, input logic en, input logic [3:0] op,
                       input ring_t et, input logic eh, input cw_t ecw, input string nm);
        sb_t s;
        if (sel == 0) begin
            reset0 = rst; step_en0 = en; opcode0 = op;
        end else begin
            reset1 = rst; step_en1 = en; opcode1 = op;
        end
        s.sel = sel; s.t = et; s.h = eh; s.cw = ecw; s.nm = nm;
        sbq.push_back(s);
        @(posedge clk);
        #1;
    endtask

    task automatic inv_check(input int sel, input logic [5:0] t, input cw_t cw);
        logic [4:0] bus;
        bus = {cw[CW_PC_EN], cw[CW_RAM_EN], cw[CW_IR_EN], cw[CW_A_EN], cw[CW_ALU_EN]};
        checks++;
        if ($onehot0(bus) && $onehot(t) && !(cw[CW_ALU_SUB] && !cw[CW_ALU_EN])) begin
            passed++;
        end else begin
            $display("FAIL invariant dut%0d: t_state=%b cw=%b (need one-hot t, one bus driver, sub only with alu_en)",
                     sel, t, cw);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if (e.sel == 0 && t_state0 == e.t && halted0 == e.h && act0 == e.cw) passed++;
                else if (e.sel == 1 && t_state1 == e.t && halted1 == e.h && act1 == e.cw) passed++;
                else if (e.sel == 0)
                    $display("FAIL %s dut0: got t=%b h=%b cw=%b, expected t=%b h=%b cw=%b",
                             e.nm, t_state0, halted0, act0, e.t, e.h, e.cw);
                else
                    $display("FAIL %s dut1: got t=%b h=%b cw=%b, expected t=%b h=%b cw=%b",
                             e.nm, t_state1, halted1, act1, e.t, e.h, e.cw);
                $display("chk %-10s dut%0d t=%b h=%b cw=%b", e.nm, e.sel, e.t, e.h, e.cw);
            end
            inv_check(0, t_state0, act0);
            inv_check(1, t_state1, act1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset0 = 1'b1; reset1 = 1'b1; step_en0 = 1'b0; step_en1 = 1'b0;
        opcode0 = OP_ADD; opcode1 = OP_SUB;
        @(posedge clk);
        #1;
        mon_on = 1'b1;

        // Short-cycle instance: SUB full length, LDA/OUT/NOP wrap early
        cyc(1, 1, 1, OP_SUB, S1, 0, W_0,   "rst1_a");
        cyc(1, 1, 1, OP_SUB, S1, 0, W_0,   "rst1_b");
        cyc(1, 0, 1, OP_SUB, S1, 0, W_T1,  "sub_t1");
        cyc(1, 0, 1, OP_SUB, S2, 0, W_T2,  "sub_t2");
        cyc(1, 0, 1, OP_SUB, S3, 0, W_T3,  "sub_t3");
        cyc(1, 0, 1, OP_SUB, S4, 0, W_ADR, "sub_t4");
        cyc(1, 0, 1, OP_SUB, S5, 0, W_LDB, "sub_t5");
        cyc(1, 0, 1, OP_SUB, S6, 0, W_SUB, "sub_t6");
        cyc(1, 0, 1, OP_LDA, S1, 0, W_T1,  "lda_t1");
        cyc(1, 0, 1, OP_LDA, S2, 0, W_T2,  "lda_t2");
        cyc(1, 0, 1, OP_LDA, S3, 0, W_T3,  "lda_t3");
        cyc(1, 0, 1, OP_LDA, S4, 0, W_ADR, "lda_t4");
        cyc(1, 0, 1, OP_LDA, S5, 0, W_LDA, "lda_t5");
        cyc(1, 0, 1, OP_OUT, S1, 0, W_T1,  "out_t1");
        cyc(1, 0, 1, OP_OUT, S2, 0, W_T2,  "out_t2");
        cyc(1, 0, 1, OP_OUT, S3, 0, W_T3,  "out_t3");
        cyc(1, 0, 1, OP_OUT, S4, 0, W_OUT, "out_t4");
        cyc(1, 0, 1, OP_NOP, S1, 0, W_T1,  "nop_t1");
        cyc(1, 0, 1, OP_NOP, S2, 0, W_T2,  "nop_t2");
        cyc(1, 0, 1, OP_NOP, S3, 0, W_T3,  "nop_t3");
        cyc(1, 0, 0, OP_NOP, S1, 0, W_T1,  "nop_wrap");

        // Full-cycle instance: ADD, single-step holds, reset mid-instruction, OUT, HLT
        cyc(0, 1, 1, OP_ADD, S1, 0, W_0,   "rst0_a");
        cyc(0, 1, 1, OP_ADD, S1, 0, W_0,   "rst0_b");
        cyc(0, 0, 1, OP_ADD, S1, 0, W_T1,  "add_t1");
        cyc(0, 0, 1, OP_ADD, S2, 0, W_T2,  "add_t2");
        cyc(0, 0, 1, OP_ADD, S3, 0, W_T3,  "add_t3");
        cyc(0, 0, 1, OP_ADD, S4, 0, W_ADR, "add_t4");
        cyc(0, 0, 1, OP_ADD, S5, 0, W_LDB, "add_t5");
        cyc(0, 0, 1, OP_ADD, S6, 0, W_ADD, "add_t6");
        cyc(0, 0, 1, OP_ADD, S1, 0, W_T1,  "add_wrap");
        cyc(0, 0, 0, OP_ADD, S2, 0, W_T2,  "hold_a");
        cyc(0, 0, 0, OP_ADD, S2, 0, W_T2,  "hold_b");
        cyc(0, 0, 1, OP_ADD, S2, 0, W_T2,  "hold_go");
        cyc(0, 0, 1, OP_ADD, S3, 0, W_T3,  "step_t3");
        cyc(0, 0, 1, OP_ADD, S4, 0, W_ADR, "step_t4");
        cyc(0, 1, 1, OP_ADD, S5, 0, W_0,   "rst_in_t5");
        cyc(0, 0, 1, OP_OUT, S1, 0, W_T1,  "post_rst");
        cyc(0, 0, 1, OP_OUT, S2, 0, W_T2,  "out0_t2");
        cyc(0, 0, 1, OP_OUT, S3, 0, W_T3,  "out0_t3");
        cyc(0, 0, 1, OP_OUT, S4, 0, W_OUT, "out0_t4");
        cyc(0, 0, 1, OP_OUT, S5, 0, W_0,   "out0_t5");
        cyc(0, 0, 1, OP_OUT, S6, 0, W_0,   "out0_t6");
        cyc(0, 0, 1, OP_HLT, S1, 0, W_T1,  "hlt_t1");
        cyc(0, 0, 1, OP_HLT, S2, 0, W_T2,  "hlt_t2");
        cyc(0, 0, 1, OP_HLT, S3, 0, W_T3,  "hlt_t3");
        cyc(0, 0, 1, OP_HLT, S4, 0, W_0,   "hlt_t4");
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 1, (i % 2 == 0) ? OP_HLT : OP_ADD, S4, 1, W_0, "halted");
        end
        cyc(0, 1, 1, OP_HLT, S4, 1, W_0,   "hlt_rst");
        cyc(0, 0, 0, OP_ADD, S1, 0, W_T1,  "hlt_exit");

        @(negedge clk);
        #1;
        mon_on = 1'b0;
        checks++;
        if (sbq.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
